datapath_control_unit: RTL and testbench

Moore control sequencer for the 3-bus CPU datapath. It decodes the latched instruction register and drives every bus-out, register-in, ALU-operation and memory strobe, one control step per Clock.
It replaces hand-sequenced T0..Tn benches with hardware fetch/decode/execute. It sits beside DataPath, and its outputs connect one-to-one to DataPath control inputs.

---
 rtl/datapath_control_unit.sv | 175 +++++++++++++++++
 tb/tb_datapath_control_unit.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_control_unit.sv
// Moore fetch/decode/execute sequencer for the 3-bus CPU datapath.
// Strobes are decoded from the state register and the latched IR opcode.
module datapath_control_unit #(
  parameter int TIMEOUT = 15,
  parameter int OPW     = 5
) (
  input  logic        Clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        mem_rdy,
  input  logic        stop,
  output logic        PCout, Zhighout, Zlowout, HIout, LOout, MDRout, Cout, BAout,
  output logic        MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zin_high, Zin_low,
  output logic        Gra, Grb, Grc, Rin, Rout,
  output logic        IncPC, Read, Write,
  output logic [3:0]  operation,
  output logic        run,
  output logic        illegal_op,
  output logic        mem_fault
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_E1, S_E2, S_E3, S_E4, S_E5, S_PAUSE, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    C_R, C_I, C_U, C_MD, C_LDI, C_LD, C_ST, C_NOP, C_HALT, C_ILL
  } cls_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   wcnt_q, wcnt_d;
  logic            fault_q, fault_d;

  logic [OPW-1:0]  opc;
  cls_e            cls;
  logic [3:0]      alu;
  state_e          last_st, done_st;
  logic            mem_step;
  logic            unused_ir;

  assign opc       = IR[31:32-OPW];
  assign unused_ir = ^IR[31-OPW:0];

  always_comb begin
    cls = C_ILL;
    alu = 4'd0;
    case (opc)
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10: begin cls = C_R; alu = opc[3:0]; end
      5'd11: begin cls = C_I;  alu = 4'b0011; end
      5'd12: begin cls = C_I;  alu = 4'b0101; end
      5'd13: begin cls = C_I;  alu = 4'b0110; end
      5'd16: begin cls = C_U;  alu = 4'b1011; end
      5'd17: begin cls = C_U;  alu = 4'b1100; end
      5'd14, 5'd15: begin cls = C_MD; alu = opc[3:0]; end
      5'd1:  begin cls = C_LDI; alu = 4'b0011; end
      5'd0:  begin cls = C_LD;  alu = 4'b0011; end
      5'd2:  begin cls = C_ST;  alu = 4'b0011; end
      5'd24: cls = C_NOP;
      5'd25: cls = C_HALT;
      default: cls = C_ILL;
    endcase
  end

  always_comb begin
    case (cls)
      C_R, C_I, C_LDI: last_st = S_E3;
      C_U:             last_st = S_E2;
      C_MD:            last_st = S_E4;
      C_LD, C_ST:      last_st = S_E5;
      default:         last_st = S_E1;
    endcase
  end

  assign done_st  = stop ? S_PAUSE : S_T0;
  assign mem_step = (state_q == S_T2) ||
                    (state_q == S_E4 && cls == C_LD) ||
                    (state_q == S_E5 && cls == C_ST);

  always_comb begin
    state_d = state_q;
    wcnt_d  = '0;
    fault_d = fault_q;
    case (state_q)
      S_RESET: state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = S_T2;
      S_T2:    state_d = S_T3;
      S_T3:    state_d = (cls == C_NOP) ? done_st : (cls == C_HALT) ? S_HALT : S_E1;
      S_E1:    state_d = (last_st == S_E1) ? done_st : S_E2;
      S_E2:    state_d = (last_st == S_E2) ? done_st : S_E3;
      S_E3:    state_d = (last_st == S_E3) ? done_st : S_E4;
      S_E4:    state_d = (last_st == S_E4) ? done_st : S_E5;
      S_E5:    state_d = done_st;
      S_PAUSE: state_d = stop ? S_PAUSE : S_T0;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
    // Memory steps hold until mem_rdy; the counter restarts on every step change.
    if (mem_step && !mem_rdy) begin
      if (wcnt_q == TLAST) begin
        state_d = S_HALT;
        fault_d = 1'b1;
      end else begin
        state_d = state_q;
        wcnt_d  = wcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_RESET;
      wcnt_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    {PCout, Zhighout, Zlowout, HIout, LOout, MDRout, Cout, BAout} = '0;
    {MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zin_high, Zin_low} = '0;
    {Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write} = '0;
    operation  = 4'd0;
    illegal_op = 1'b0;
    case (state_q)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin_low = 1'b1; end
      S_T1: begin Zlowout = 1'b1; PCin = 1'b1; end
      S_T2: begin Read = 1'b1; MDRin = 1'b1; end
      S_T3: begin MDRout = 1'b1; IRin = 1'b1; end
      S_E1: case (cls)
        C_R, C_I:          begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
        C_U:               begin Grb = 1'b1; Rout = 1'b1; Zin_low = 1'b1; operation = alu; end
        C_MD:              begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
        C_LDI, C_LD, C_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
        C_ILL:             illegal_op = 1'b1;
        default: ;
      endcase
      S_E2: case (cls)
        C_R:                    begin Grc = 1'b1; Rout = 1'b1; Zin_low = 1'b1; operation = alu; end
        C_I, C_LDI, C_LD, C_ST: begin Cout = 1'b1; Zin_low = 1'b1; operation = alu; end
        C_U:                    begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        C_MD: begin
          Grb = 1'b1; Rout = 1'b1; Zin_low = 1'b1; Zin_high = 1'b1; operation = alu;
        end
        default: ;
      endcase
      S_E3: case (cls)
        C_R, C_I, C_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        C_MD:            begin Zlowout = 1'b1; LOin = 1'b1; end
        C_LD, C_ST:      begin Zlowout = 1'b1; MARin = 1'b1; end
        default: ;
      endcase
      S_E4: case (cls)
        C_MD: begin Zhighout = 1'b1; HIin = 1'b1; end
        C_LD: begin Read = 1'b1; MDRin = 1'b1; end
        C_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
        default: ;
      endcase
      S_E5: case (cls)
        C_LD: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        C_ST: Write = 1'b1;
        default: ;
      endcase
      default: ;
    endcase
  end

  assign run       = (state_q != S_RESET) && (state_q != S_PAUSE) && (state_q != S_HALT);
  assign mem_fault = fault_q;
endmodule

// File: tb/tb_datapath_control_unit.sv
// Directed bench for datapath_control_unit: per-step strobe tables per opcode class,
// memory waits, timeout, stop/pause, halt, illegal opcode and async clear.
module tb_datapath_control_unit;
  logic        Clock = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] IR = '0;
  logic        mem_rdy = 1'b1;
  logic        stop = 1'b0;
  logic PCout, Zhighout, Zlowout, HIout, LOout, MDRout, Cout, BAout;
  logic MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zin_high, Zin_low;
  logic Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write;
  logic [3:0] operation;
  logic run, illegal_op, mem_fault;

  int errors = 0;
  int checks = 0;

  datapath_control_unit dut (
    .Clock(Clock), .clear(clear), .IR(IR), .mem_rdy(mem_rdy), .stop(stop),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .HIout(HIout), .LOout(LOout),
    .MDRout(MDRout), .Cout(Cout), .BAout(BAout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .HIin(HIin),
    .LOin(LOin), .Zin_high(Zin_high), .Zin_low(Zin_low),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .IncPC(IncPC), .Read(Read), .Write(Write),
    .operation(operation), .run(run), .illegal_op(illegal_op), .mem_fault(mem_fault)
  );

  always #5 Clock = ~Clock;

  logic [24:0] strb;
  assign strb = {PCout, Zhighout, Zlowout, HIout, LOout, MDRout, Cout, BAout,
                 MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zin_high, Zin_low,
                 Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write};

  localparam logic [24:0] B_PCout = 25'(1) << 24, B_Zhighout = 25'(1) << 23;
  localparam logic [24:0] B_Zlowout = 25'(1) << 22, B_MDRout = 25'(1) << 19;
  localparam logic [24:0] B_Cout = 25'(1) << 18, B_BAout = 25'(1) << 17;
  localparam logic [24:0] B_MARin = 25'(1) << 16, B_PCin = 25'(1) << 15;
  localparam logic [24:0] B_MDRin = 25'(1) << 14, B_IRin = 25'(1) << 13;
  localparam logic [24:0] B_Yin = 25'(1) << 12, B_HIin = 25'(1) << 11;
  localparam logic [24:0] B_LOin = 25'(1) << 10, B_Zinh = 25'(1) << 9;
  localparam logic [24:0] B_Zinl = 25'(1) << 8, B_Gra = 25'(1) << 7;
  localparam logic [24:0] B_Grb = 25'(1) << 6, B_Grc = 25'(1) << 5;
  localparam logic [24:0] B_Rin = 25'(1) << 4, B_Rout = 25'(1) << 3;
  localparam logic [24:0] B_IncPC = 25'(1) << 2, B_Read = 25'(1) << 1, B_Write = 25'(1);

  localparam logic [24:0] F0 = B_PCout | B_MARin | B_IncPC | B_Zinl;
  localparam logic [24:0] F1 = B_Zlowout | B_PCin;
  localparam logic [24:0] F2 = B_Read | B_MDRin;
  localparam logic [24:0] F3 = B_MDRout | B_IRin;

  // Reset pulse; returns on the falling edge where the DUT sits in T0.
  task automatic do_reset();
    @(negedge Clock); clear = 1'b0;
    @(negedge Clock); clear = 1'b1;
    @(negedge Clock);
  endtask

  task automatic test_reset();
    clear = 1'b0; IR = 32'h1891_8000; mem_rdy = 1'b1; stop = 1'b0;
    #12;
    checks++;
    if ({strb, operation, run, illegal_op, mem_fault} !== 32'd0) begin
      errors++;
      $display("FAIL reset outputs: got %h op %h run %b ill %b flt %b, want all 0",
               strb, operation, run, illegal_op, mem_fault);
    end
    @(negedge Clock);
    checks++;
    if ({strb, run} !== 26'd0) begin
      errors++; $display("FAIL reset held: got %h run %b, want 0", strb, run);
    end
  endtask

  task automatic test_add();
    logic [24:0] ev [8];
    logic [3:0]  eo [8];
    ev = '{F0, F1, F2, F3, B_Grb | B_Rout | B_Yin, B_Grc | B_Rout | B_Zinl,
           B_Zlowout | B_Gra | B_Rin, F0};
    eo = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'b0011, 4'd0, 4'd0};
    IR = 32'h1891_8000; mem_rdy = 1'b1; stop = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({strb, operation, run} !== {ev[i], eo[i], 1'b1}) begin
        errors++;
        $display("FAIL add step %0d: got %h op %h run %b, want %h op %h run 1",
                 i, strb, operation, run, ev[i], eo[i]);
      end
      @(negedge Clock);
    end
  endtask

  task automatic test_ld_wait();
    logic [24:0] ev [13];
    logic [3:0]  eo [13];
    ev = '{F0, F1, F2, F3, B_Grb | B_BAout | B_Yin, B_Cout | B_Zinl, B_Zlowout | B_MARin,
           F2, F2, F2, F2, B_MDRout | B_Gra | B_Rin, F0};
    eo = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'b0011, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    IR = 32'h0090_0055; mem_rdy = 1'b1; stop = 1'b0;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      checks++;
      if ({strb, operation, run} !== {ev[i], eo[i], 1'b1}) begin
        errors++;
        $display("FAIL ld step %0d: got %h op %h run %b, want %h op %h run 1",
                 i, strb, operation, run, ev[i], eo[i]);
      end
      if (i == 6) mem_rdy = 1'b0;
      if (i == 10) mem_rdy = 1'b1;
      @(negedge Clock);
    end
  endtask

  task automatic test_mul();
    logic [24:0] ev [9];
    logic [3:0]  eo [9];
    ev = '{F0, F1, F2, F3, B_Gra | B_Rout | B_Yin, B_Grb | B_Rout | B_Zinl | B_Zinh,
           B_Zlowout | B_LOin, B_Zhighout | B_HIin, F0};
    eo = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'b1110, 4'd0, 4'd0, 4'd0};
    IR = 32'h7000_0000; mem_rdy = 1'b1; stop = 1'b0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      checks++;
      if ({strb, operation, run} !== {ev[i], eo[i], 1'b1}) begin
        errors++;
        $display("FAIL mul step %0d: got %h op %h run %b, want %h op %h run 1",
                 i, strb, operation, run, ev[i], eo[i]);
      end
      @(negedge Clock);
    end
  endtask

  task automatic test_timeout();
    logic [24:0] e;
    IR = 32'h1891_8000; mem_rdy = 1'b0; stop = 1'b0;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      e = (i == 0) ? F0 : (i == 1) ? F1 : F2;
      checks++;
      if ({strb, run, mem_fault} !== {e, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL timeout wait %0d: got %h run %b flt %b, want %h run 1 flt 0",
                 i, strb, run, mem_fault, e);
      end
      @(negedge Clock);
    end
    checks++;
    if ({strb, run, mem_fault} !== {25'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL timeout halt: got %h run %b flt %b, want 0 run 0 flt 1", strb, run, mem_fault);
    end
    mem_rdy = 1'b1;
    repeat (3) @(negedge Clock);
    checks++;
    if ({strb, run, mem_fault} !== {25'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL timeout sticky: got %h run %b flt %b, want 0 run 0 flt 1", strb, run, mem_fault);
    end
    clear = 1'b0;
    #1;
    checks++;
    if (mem_fault !== 1'b0) begin
      errors++; $display("FAIL fault clear: got %b, want 0", mem_fault);
    end
    @(negedge Clock); clear = 1'b1;
  endtask

  task automatic test_halt();
    logic [24:0] ev [4];
    ev = '{F0, F1, F2, F3};
    IR = 32'hC800_0000; mem_rdy = 1'b1; stop = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({strb, run} !== {ev[i], 1'b1}) begin
        errors++; $display("FAIL halt fetch %0d: got %h run %b, want %h run 1", i, strb, run, ev[i]);
      end
      @(negedge Clock);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({strb, operation, run} !== 30'd0) begin
        errors++; $display("FAIL halt hold %0d: got %h op %h run %b, want 0", i, strb, operation, run);
      end
      stop = ~stop; mem_rdy = ~mem_rdy;
      @(negedge Clock);
    end
    stop = 1'b0; mem_rdy = 1'b1;
    #2 clear = 1'b0;
    #1;
    checks++;
    if ({strb, run} !== 26'd0) begin
      errors++; $display("FAIL halt clear: got %h run %b, want 0", strb, run);
    end
    @(negedge Clock); clear = 1'b1;
    @(negedge Clock);
    checks++;
    if ({strb, run} !== {F0, 1'b1}) begin
      errors++; $display("FAIL halt restart: got %h run %b, want %h run 1", strb, run, F0);
    end
  endtask

  task automatic test_async_clear();
    IR = 32'h1891_8000; mem_rdy = 1'b1; stop = 1'b0;
    do_reset();
    @(negedge Clock);
    checks++;
    if ({strb, run} !== {F1, 1'b1}) begin
      errors++; $display("FAIL async pre: got %h run %b, want %h run 1", strb, run, F1);
    end
    #2 clear = 1'b0;
    #1;
    checks++;
    if ({strb, run} !== 26'd0) begin
      errors++; $display("FAIL async clear: got %h run %b, want 0", strb, run);
    end
    @(negedge Clock); clear = 1'b1;
    @(negedge Clock);
    checks++;
    if ({strb, run} !== {F0, 1'b1}) begin
      errors++; $display("FAIL async restart: got %h run %b, want %h run 1", strb, run, F0);
    end
  endtask

  task automatic test_stop();
    logic [24:0] ev [7];
    ev = '{F0, F1, F2, F3, B_Grb | B_Rout | B_Yin, B_Grc | B_Rout | B_Zinl, B_Zlowout | B_Gra | B_Rin};
    IR = 32'h1891_8000; mem_rdy = 1'b1; stop = 1'b0;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      checks++;
      if ({strb, run} !== {ev[i], 1'b1}) begin
        errors++; $display("FAIL stop step %0d: got %h run %b, want %h run 1", i, strb, run, ev[i]);
      end
      if (i == 5) stop = 1'b1;
      @(negedge Clock);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({strb, run} !== 26'd0) begin
        errors++; $display("FAIL pause %0d: got %h run %b, want 0 run 0", i, strb, run);
      end
      if (i == 1) stop = 1'b0;
      @(negedge Clock);
    end
    checks++;
    if ({strb, run} !== {F0, 1'b1}) begin
      errors++; $display("FAIL pause resume: got %h run %b, want %h run 1", strb, run, F0);
    end
  endtask

  task automatic test_illegal();
    logic [24:0] ev [6];
    logic        ei [6];
    ev = '{F0, F1, F2, F3, 25'd0, F0};
    ei = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    IR = 32'hF800_0000; mem_rdy = 1'b1; stop = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({strb, illegal_op, run} !== {ev[i], ei[i], 1'b1}) begin
        errors++;
        $display("FAIL illegal step %0d: got %h ill %b run %b, want %h ill %b run 1",
                 i, strb, illegal_op, run, ev[i], ei[i]);
      end
      @(negedge Clock);
    end
  endtask

  task automatic test_nop();
    logic [24:0] ev [5];
    ev = '{F0, F1, F2, F3, F0};
    IR = 32'hC000_0000; mem_rdy = 1'b1; stop = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({strb, operation, run} !== {ev[i], 4'd0, 1'b1}) begin
        errors++; $display("FAIL nop step %0d: got %h op %h run %b, want %h", i, strb, operation, run, ev[i]);
      end
      @(negedge Clock);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ld_wait();
    test_mul();
    test_timeout();
    test_halt();
    test_async_clear();
    test_stop();
    test_illegal();
    test_nop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
